csi2_rx_depacker: RTL
=====================

CSI2_RX_DEPACKER -- requirements
Module: csi2_rx_depacker

Interface
REQ-001 SHALL have parameter LANE_COUNT, default 2, meaning D-PHY data lanes (1, 2 or 4).
REQ-002 SHALL have parameter GEAR, default 16, meaning bits per lane per clock (8 or 16); B = LANE_COUNT*GEAR/8 bytes per beat, with B <= 4 (elaboration error otherwise).
REQ-003 SHALL have port clk_i, input, 1 bit, byte clock; the block uses one clock; reset is synchronous and active-low.
REQ-004 SHALL have port reset_n_i, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port sp_en_i, input, 1 bit, short-packet header strobe (dt_i valid).
REQ-006 SHALL have port lp_av_en_i, input, 1 bit, long-packet header strobe (dt_i and wc_i valid).
REQ-007 SHALL have port dt_i, input, 6 bits, data type.
REQ-008 SHALL have port wc_i, input, 16 bits, long-packet byte count.
REQ-009 SHALL have port payload_i, input, LANE_COUNT*GEAR bits, payload beat; bits [7:0] hold the earliest byte.
REQ-010 SHALL have port payload_en_i, input, 1 bit, payload beat valid.
REQ-011 SHALL have port pd_o, output, 48 bits, four 12-bit MSB-aligned pixels; pixel 0 is in [11:0].
REQ-012 SHALL have port pix_en_o, output, 1 bit, pd_o valid.
REQ-013 SHALL have ports fv_o and lv_o, output, 1 bit each, frame-valid and line-valid.
REQ-014 SHALL have port err_o, output, 3 bits, one-cycle error pulses: [0] wc not a unit multiple, [1] short line, [2] frame start while fv_o high.
REQ-015 SHALL have ports frame_cnt_o and line_cnt_o, output, 16 bits each.

Function
REQ-016 SHALL set unit bytes U = 4/5/6 for dt 0x2A/0x2B/0x2C (RAW8/10/12); every unit yields one 4-pixel group.
REQ-017 SHALL unpack as follows: RAW8 px={Bn,4'h0}; RAW10 px n={Bn,B4[2n+1:2n],2'b0}; RAW12 px0/1={B0,B2[3:0]},{B1,B2[7:4]}, and px2/3 likewise from B3..B5.
REQ-018 SHALL implement states IDLE, LINE, FLUSH and DROP: IDLE->LINE on lp_av_en_i with a supported dt; IDLE->DROP on lp_av_en_i with any other dt; LINE->FLUSH once wc bytes are accepted; FLUSH->IDLE when the buffer is empty; DROP->IDLE once wc bytes are consumed.
REQ-019 SHALL accept bytes only in LINE; bytes beyond wc in the final beat SHALL be discarded.
REQ-020 SHALL use a 12-byte accumulation buffer and emit at most one group per cycle, registered, one cycle after the cycle in which the group's last byte was accepted.
REQ-021 SHALL assert lv_o with the first pix_en_o of a line and deassert it the cycle after the last group.
REQ-022 SHALL handle wc mod U != 0 by zero-padding the final group, emitting it, and pulsing err_o[0].
REQ-023 SHALL, if an lp_av_en_i or sp_en_i arrives while in LINE, pulse err_o[1], zero-pad and flush the partial data, then process the new header.
REQ-024 SHALL set fv_o on a short packet with dt 0x00; a short packet with dt 0x01 SHALL clear fv_o, deferred until FLUSH completes.
REQ-025 SHALL, on dt 0x00 while fv_o=1, pulse err_o[2] and restart the frame.
REQ-026 SHALL increment frame_cnt_o on each frame start and clear line_cnt_o at that point; line_cnt_o SHALL increment at each line end; both counters wrap at 0xFFFF->0.

Reset
REQ-027 SHALL, when reset_n_i=0 at a clk_i edge, return to IDLE, empty the buffer, and clear pd_o, pix_en_o, fv_o, lv_o, err_o and both counters to 0, including mid-line.

Configuration
REQ-028 SHALL, with CSI2_DPK_STATS_EN defined, implement err_o, frame_cnt_o and line_cnt_o as specified; without it those outputs SHALL be tied to 0 and the pixel path SHALL be unchanged.

Structure
REQ-029 SHALL place the DT constants, the state enum and the unit-size function in package csi2_dpk_pkg.
REQ-030 SHALL implement unpacking in sub-module csi2_unpack_unit, which maps U bytes plus dt to pd.

Verification
REQ-031 SHALL cover: 2 lanes, GEAR 16, RAW10, wc=10, bytes 0x01..0x0A -> two groups, first pixel 0 = 0x010 | (B4[1:0]<<2), lv_o high for 2 cycles.
REQ-032 SHALL cover: RAW8, wc=7 -> two groups, the last padded with 0x000 pixels, err_o[0] pulses once.
REQ-033 SHALL cover: FS, 3 lines, FE -> fv_o falls after the last group, line_cnt_o=3, frame_cnt_o=1.
REQ-034 SHALL cover: dt 0x12 long packet with wc=8 -> no pix_en_o, and the state returns to IDLE.
REQ-035 SHALL cover: reset_n_i low mid-line -> all outputs 0 the next cycle, and the next line decodes cleanly.
REQ-036 SHALL cover: a build without CSI2_DPK_STATS_EN running the scenario of REQ-033 -> identical pd_o/pix_en_o and counters stuck at 0.

Source files
------------

// File: rtl/csi2_dpk_pkg.sv
// csi2_dpk_pkg
// Shared definitions for the CSI-2 RX depacker:
//   - data-type codes for frame start/end and RAW8/10/12 long packets
//   - depacker FSM state encoding
//   - unit_size(): bytes per 4-pixel group for a data type (0 = unsupported)
package csi2_dpk_pkg;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LINE  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  // A zero return marks a data type the depacker does not decode.
  function automatic logic [2:0] unit_size(input logic [5:0] dt);
    logic [2:0] u;
    case (dt)
      DT_RAW8:  u = 3'd4;
      DT_RAW10: u = 3'd5;
      DT_RAW12: u = 3'd6;
      default:  u = 3'd0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/csi2_unpack_unit.sv
// csi2_unpack_unit
// Combinational unpacker: turns one packing unit (4, 5 or 6 bytes depending
// on the data type) into four 12-bit MSB-aligned pixels.
// Ports:
//   bytes_i [47:0] unit bytes, byte n in [8n+7:8n]; unused upper bytes ignored
//   dt_i    [5:0]  data type of the unit
//   pd_o    [47:0] four pixels, pixel n in [12n+11:12n]; zero for other types
module csi2_unpack_unit
  import csi2_dpk_pkg::*;
(
  input  logic [47:0] bytes_i,
  input  logic [5:0]  dt_i,
  output logic [47:0] pd_o
);

  logic [7:0] b [6];

  for (genvar gi = 0; gi < 6; gi++) begin : g_bytes
    assign b[gi] = bytes_i[gi*8 +: 8];
  end

  always_comb begin
    pd_o = '0;
    case (dt_i)
      DT_RAW8: begin
        for (int n = 0; n < 4; n++) begin
          pd_o[n*12 +: 12] = {b[n], 4'h0};
        end
      end
      DT_RAW10: begin
        // Byte 4 carries the two LSBs of each pixel, pixel 0 in bits [1:0].
        for (int n = 0; n < 4; n++) begin
          pd_o[n*12 +: 12] = {b[n], b[4][2*n +: 2], 2'b00};
        end
      end
      DT_RAW12: begin
        pd_o[11:0]  = {b[0], b[2][3:0]};
        pd_o[23:12] = {b[1], b[2][7:4]};
        pd_o[35:24] = {b[3], b[5][3:0]};
        pd_o[47:36] = {b[4], b[5][7:4]};
      end
      default: pd_o = '0;
    endcase
  end

endmodule

// File: rtl/csi2_rx_depacker.sv
// csi2_rx_depacker
// Converts CSI-2 long-packet payload (RAW8/RAW10/RAW12) into 4-pixel groups
// and tracks frame/line framing from short packets.
// Optional feature macro: CSI2_DPK_STATS_EN enables err_o, frame_cnt_o and
// line_cnt_o; without it those outputs are held at zero.
// Ports:
//   clk_i         byte clock
//   reset_n_i     synchronous active-low reset
//   sp_en_i       short-packet header strobe (dt_i valid)
//   lp_av_en_i    long-packet header strobe (dt_i, wc_i valid)
//   dt_i, wc_i    data type and long-packet byte count
//   payload_i     payload beat, earliest byte in [7:0]
//   payload_en_i  payload beat valid
//   pd_o          four 12-bit pixels, pixel 0 in [11:0]
//   pix_en_o      pd_o valid
//   fv_o, lv_o    frame valid, line valid
//   err_o         pulses: [0] wc not unit multiple, [1] short line,
//                 [2] frame start inside a frame
//   frame_cnt_o, line_cnt_o  frame and line counters
module csi2_rx_depacker
  import csi2_dpk_pkg::*;
#(
  parameter int LANE_COUNT = 2,
  parameter int GEAR       = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       sp_en_i,
  input  logic                       lp_av_en_i,
  input  logic [5:0]                 dt_i,
  input  logic [15:0]                wc_i,
  input  logic [LANE_COUNT*GEAR-1:0] payload_i,
  input  logic                       payload_en_i,
  output logic [47:0]                pd_o,
  output logic                       pix_en_o,
  output logic                       fv_o,
  output logic                       lv_o,
  output logic [2:0]                 err_o,
  output logic [15:0]                frame_cnt_o,
  output logic [15:0]                line_cnt_o
);

  localparam int B = LANE_COUNT * GEAR / 8;

  if (!((LANE_COUNT == 1 || LANE_COUNT == 2 || LANE_COUNT == 4) &&
        (GEAR == 8 || GEAR == 16) && B <= 4)) begin : g_bad_cfg
    $error("csi2_rx_depacker: unsupported LANE_COUNT/GEAR combination");
  end

  localparam logic [15:0] B16 = 16'(B);
  localparam logic [2:0]  B3  = 3'(B);

`ifdef CSI2_DPK_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [95:0] buf_q, buf_d;          // 12-byte accumulation buffer, byte 0 oldest
  logic [3:0]  cnt_q, cnt_d;          // valid bytes in buf_q
  logic [15:0] rem_q, rem_d;          // payload bytes still expected
  logic [5:0]  dt_q, dt_d;
  logic [2:0]  unit_q, unit_d;
  logic [47:0] pd_q, pd_d;
  logic        pix_en_q, pix_en_d;
  logic        fv_q, fv_d;
  logic        lv_q, lv_d;
  logic        started_q, started_d;  // current line has emitted a group
  logic        fe_pend_q, fe_pend_d;  // frame end waiting for the line to drain
  logic [2:0]  err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;

  logic        hdr;
  logic        flush;
  logic [2:0]  take;
  logic [2:0]  take_line;
  logic [3:0]  comb_cnt;
  logic [95:0] comb_buf;
  logic [47:0] unpacked;
  logic [2:0]  hdr_unit;

  assign hdr       = lp_av_en_i | sp_en_i;
  assign hdr_unit  = unit_size(dt_i);
  // Bytes of this beat that belong to the packet; the rest are discarded.
  assign take      = (rem_q < B16) ? rem_q[2:0] : B3;
  assign take_line = (state_q == ST_LINE && payload_en_i && !hdr) ? take : 3'd0;
  assign comb_cnt  = cnt_q + {1'b0, take_line};
  // A header while a line is open aborts it; FLUSH drains the tail.
  assign flush     = (state_q == ST_FLUSH) || (state_q == ST_LINE && hdr);

  // Buffer contents as if this cycle's bytes were already appended. Bytes at
  // or above cnt_q are always zero, which gives the zero padding for free.
  always_comb begin
    comb_buf = buf_q;
    for (int k = 0; k < B; k++) begin
      if (k < int'(take_line)) begin
        comb_buf[(int'(cnt_q) + k)*8 +: 8] = payload_i[k*8 +: 8];
      end
    end
  end

  csi2_unpack_unit u_unpack (
    .bytes_i (comb_buf[47:0]),
    .dt_i    (dt_q),
    .pd_o    (unpacked)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dt_d        = dt_q;
    unit_d      = unit_q;
    pd_d        = pd_q;
    pix_en_d    = 1'b0;
    fv_d        = fv_q;
    lv_d        = lv_q;
    started_d   = started_q;
    fe_pend_d   = fe_pend_q;
    err_d       = 3'b000;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;

    case (state_q)
      ST_IDLE: begin
        lv_d      = 1'b0;
        started_d = 1'b0;
        if (fe_pend_q) begin
          fv_d      = 1'b0;
          fe_pend_d = 1'b0;
        end
      end
      ST_DROP: begin
        lv_d      = 1'b0;
        started_d = 1'b0;
        if (payload_en_i && !hdr) begin
          rem_d = rem_q - {13'd0, take};
          if (rem_d == 16'd0) state_d = ST_IDLE;
        end
      end
      ST_LINE: begin
        if (!hdr) begin
          rem_d = rem_q - {13'd0, take_line};
          if (comb_cnt >= {1'b0, unit_q}) begin
            pd_d      = unpacked;
            pix_en_d  = 1'b1;
            started_d = 1'b1;
            buf_d     = comb_buf >> {unit_q, 3'b000};
            cnt_d     = comb_cnt - {1'b0, unit_q};
          end else begin
            buf_d = comb_buf;
            cnt_d = comb_cnt;
          end
          lv_d = started_d;
          if (rem_d == 16'd0) state_d = ST_FLUSH;
        end
      end
      default: ;
    endcase

    // Line end: a partial unit left in the buffer goes out zero-padded.
    if (flush) begin
      if (cnt_q != 4'd0) begin
        pd_d     = unpacked;
        pix_en_d = 1'b1;
        err_d[0] = (state_q == ST_FLUSH);
      end
      err_d[1]   = (state_q == ST_LINE);
      lv_d       = (cnt_q != 4'd0);
      started_d  = 1'b0;
      buf_d      = '0;
      cnt_d      = 4'd0;
      line_cnt_d = line_cnt_q + 16'd1;
      state_d    = ST_IDLE;
    end

    if (hdr) begin
      if (lp_av_en_i) begin
        rem_d = wc_i;
        if (hdr_unit != 3'd0) begin
          dt_d    = dt_i;
          unit_d  = hdr_unit;
          state_d = (wc_i == 16'd0) ? ST_FLUSH : ST_LINE;
        end else begin
          state_d = (wc_i == 16'd0) ? ST_IDLE : ST_DROP;
        end
      end else begin
        state_d = ST_IDLE;
        if (dt_i == DT_FS) begin
          err_d[2]    = fv_q;
          fv_d        = 1'b1;
          fe_pend_d   = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          line_cnt_d  = 16'd0;
        end else if (dt_i == DT_FE) begin
          // Keep fv_o up until the last group of the line has been output.
          if (state_q == ST_LINE || state_q == ST_FLUSH) fe_pend_d = 1'b1;
          else                                           fv_d      = 1'b0;
        end
      end
    end

    if (!STATS_EN) begin
      err_d       = 3'b000;
      frame_cnt_d = 16'd0;
      line_cnt_d  = 16'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      cnt_q       <= 4'd0;
      rem_q       <= 16'd0;
      dt_q        <= 6'd0;
      unit_q      <= 3'd0;
      pd_q        <= '0;
      pix_en_q    <= 1'b0;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      started_q   <= 1'b0;
      fe_pend_q   <= 1'b0;
      err_q       <= 3'b000;
      frame_cnt_q <= 16'd0;
      line_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dt_q        <= dt_d;
      unit_q      <= unit_d;
      pd_q        <= pd_d;
      pix_en_q    <= pix_en_d;
      fv_q        <= fv_d;
      lv_q        <= lv_d;
      started_q   <= started_d;
      fe_pend_q   <= fe_pend_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign pd_o        = pd_q;
  assign pix_en_o    = pix_en_q;
  assign fv_o        = fv_q;
  assign lv_o        = lv_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;
  assign line_cnt_o  = line_cnt_q;

endmodule
